// File: rtl/param_wb_cache.sv
// param_wb_cache: set-associative (1 or 2 ways), write-back, write-allocate data
// cache between the EM stage and a line-wide RAM, with LRU replacement, flush
// and saturating hit/miss counters.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU access (held until cpu_ready)
//   cpu_rdata, cpu_ready                load data / access complete (combinational)
//   flush, flush_done                   flush request pulse / completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata   registered line transaction to RAM
//   mem_rdata, mem_ready                refill line / transaction complete
//   hit_cnt, miss_cnt                   saturating statistics
module param_wb_cache #(
  parameter int unsigned DATA_W         = 10,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned WORDS_PER_LINE = 2,
  parameter int unsigned SETS           = 4,
  parameter int unsigned WAYS           = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cpu_req,
  input  logic                             cpu_we,
  input  logic [ADDR_W-1:0]                cpu_addr,
  input  logic [DATA_W-1:0]                cpu_wdata,
  output logic [DATA_W-1:0]                cpu_rdata,
  output logic                             cpu_ready,
  input  logic                             flush,
  output logic                             flush_done,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W*WORDS_PER_LINE-1:0] mem_wdata,
  input  logic [DATA_W*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                             mem_ready,
  output logic [CNT_W-1:0]                 hit_cnt,
  output logic [CNT_W-1:0]                 miss_cnt
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINE_W = DATA_W * WORDS_PER_LINE;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITEBACK, S_REFILL, S_FLUSH_SCAN, S_FLUSH_WB
  } state_t;

  // Storage: arrays always hold two ways; way 1 is simply unused when WAYS == 1.
  logic [LINE_W-1:0]     r_data [2][SETS];
  logic [TAG_W-1:0]      r_tag  [2][SETS];
  logic [1:0][SETS-1:0]  r_valid;
  logic [1:0][SETS-1:0]  r_dirty;
  logic [SETS-1:0]       r_lru;          // way to evict next

  state_t                r_state, w_state_nx;
  logic                  r_mem_req, w_mem_req_nx;
  logic                  r_mem_we, w_mem_we_nx;
  logic [ADDR_W-1:0]     r_mem_addr, w_mem_addr_nx;
  logic [LINE_W-1:0]     r_mem_wdata, w_mem_wdata_nx;
  logic                  r_victim, w_victim_nx;
  logic [IDX_W-1:0]      r_scan_set, w_scan_set_nx;
  logic                  r_scan_way, w_scan_way_nx;
  logic                  r_flush_done, w_flush_done_nx;
  logic                  r_refilled, w_refilled_nx;  // suppresses hit count on re-lookup
  logic                  r_flush_pend;
  logic [CNT_W-1:0]      r_hit_cnt, r_miss_cnt;

  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_idx;
  logic [OFF_W-1:0]      w_off;
  logic [1:0]            w_match;
  logic                  w_hit, w_hit_way, w_victim, w_vic_dirty;
  logic [LINE_W-1:0]     w_hit_line;
  logic [DATA_W-1:0]     w_hit_word;
  logic                  w_scan_dirty, w_scan_last;
  logic                  w_cpu_ready, w_hit_inc, w_miss_inc, w_store_hit;
  logic                  w_refill_wr, w_flush_clr, w_lru_upd, w_flush_start;

  assign w_tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_idx = cpu_addr[OFF_W +: IDX_W];
  assign w_off = cpu_addr[OFF_W-1:0];

  // Tag lookup and word select
  assign w_match[0] = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_match[1] = (WAYS == 2) && r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit      = |w_match;
  assign w_hit_way  = w_match[1];
  assign w_hit_line = r_data[w_hit_way][w_idx];
  assign w_hit_word = w_hit_line[32'(w_off)*DATA_W +: DATA_W];

  // Victim: first invalid way, else LRU way
  always_comb begin
    w_victim = 1'b0;
    if (WAYS == 2) begin
      if (!r_valid[0][w_idx])      w_victim = 1'b0;
      else if (!r_valid[1][w_idx]) w_victim = 1'b1;
      else                         w_victim = r_lru[w_idx];
    end
  end
  assign w_vic_dirty  = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

  assign w_scan_dirty = r_valid[r_scan_way][r_scan_set] && r_dirty[r_scan_way][r_scan_set];
  assign w_scan_last  = (r_scan_set == IDX_W'(SETS-1)) && (r_scan_way == 1'(WAYS-1));

  // Next-state and control
  always_comb begin
    w_state_nx      = r_state;
    w_mem_req_nx    = r_mem_req;
    w_mem_we_nx     = r_mem_we;
    w_mem_addr_nx   = r_mem_addr;
    w_mem_wdata_nx  = r_mem_wdata;
    w_victim_nx     = r_victim;
    w_scan_set_nx   = r_scan_set;
    w_scan_way_nx   = r_scan_way;
    w_flush_done_nx = 1'b0;
    w_refilled_nx   = r_refilled;
    w_cpu_ready     = 1'b0;
    w_hit_inc       = 1'b0;
    w_miss_inc      = 1'b0;
    w_store_hit     = 1'b0;
    w_refill_wr     = 1'b0;
    w_flush_clr     = 1'b0;
    w_lru_upd       = 1'b0;
    w_flush_start   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_refilled_nx = 1'b0;
        if (cpu_req) begin
          if (w_hit) begin
            w_cpu_ready = 1'b1;
            w_lru_upd   = 1'b1;
            w_store_hit = cpu_we;
            w_hit_inc   = !r_refilled;
          end else begin
            w_miss_inc   = 1'b1;
            w_victim_nx  = w_victim;
            w_mem_req_nx = 1'b1;
            if (w_vic_dirty) begin
              w_state_nx     = S_WRITEBACK;
              w_mem_we_nx    = 1'b1;
              w_mem_addr_nx  = {r_tag[w_victim][w_idx], w_idx, OFF_W'(0)};
              w_mem_wdata_nx = r_data[w_victim][w_idx];
            end else begin
              w_state_nx    = S_REFILL;
              w_mem_we_nx   = 1'b0;
              w_mem_addr_nx = {w_tag, w_idx, OFF_W'(0)};
            end
          end
        end else begin
          w_cpu_ready = 1'b1;
          if (r_flush_pend) begin
            w_state_nx    = S_FLUSH_SCAN;
            w_scan_set_nx = '0;
            w_scan_way_nx = 1'b0;
            w_flush_start = 1'b1;
          end
        end
      end
      S_WRITEBACK: begin
        if (r_mem_req && mem_ready) begin
          w_mem_req_nx = 1'b0;
          w_state_nx   = S_REFILL;
        end
      end
      S_REFILL: begin
        // Entered idle after a writeback: raise the read one cycle later
        if (!r_mem_req) begin
          w_mem_req_nx  = 1'b1;
          w_mem_we_nx   = 1'b0;
          w_mem_addr_nx = {w_tag, w_idx, OFF_W'(0)};
        end else if (mem_ready) begin
          w_mem_req_nx  = 1'b0;
          w_refill_wr   = 1'b1;
          w_refilled_nx = 1'b1;
          w_state_nx    = S_IDLE;
        end
      end
      S_FLUSH_SCAN: begin
        if (w_scan_dirty) begin
          w_state_nx     = S_FLUSH_WB;
          w_mem_req_nx   = 1'b1;
          w_mem_we_nx    = 1'b1;
          w_mem_addr_nx  = {r_tag[r_scan_way][r_scan_set], r_scan_set, OFF_W'(0)};
          w_mem_wdata_nx = r_data[r_scan_way][r_scan_set];
        end else if (w_scan_last) begin
          w_flush_done_nx = 1'b1;
          w_state_nx      = S_IDLE;
        end else if (r_scan_way == 1'(WAYS-1)) begin
          w_scan_way_nx = 1'b0;
          w_scan_set_nx = r_scan_set + IDX_W'(1);
        end else begin
          w_scan_way_nx = 1'b1;
        end
      end
      S_FLUSH_WB: begin
        // Return to the same scan slot; its dirty bit is clear so the scan moves on
        if (r_mem_req && mem_ready) begin
          w_mem_req_nx = 1'b0;
          w_flush_clr  = 1'b1;
          w_state_nx   = S_FLUSH_SCAN;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_victim     <= 1'b0;
      r_scan_set   <= '0;
      r_scan_way   <= 1'b0;
      r_flush_done <= 1'b0;
      r_refilled   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_lru        <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_mem_req    <= w_mem_req_nx;
      r_mem_we     <= w_mem_we_nx;
      r_mem_addr   <= w_mem_addr_nx;
      r_mem_wdata  <= w_mem_wdata_nx;
      r_victim     <= w_victim_nx;
      r_scan_set   <= w_scan_set_nx;
      r_scan_way   <= w_scan_way_nx;
      r_flush_done <= w_flush_done_nx;
      r_refilled   <= w_refilled_nx;
      if (flush)              r_flush_pend <= 1'b1;
      else if (w_flush_start) r_flush_pend <= 1'b0;
      if (w_hit_inc && (r_hit_cnt != {CNT_W{1'b1}}))   r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
      if (w_miss_inc && (r_miss_cnt != {CNT_W{1'b1}})) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      if (w_store_hit) r_dirty[w_hit_way][w_idx] <= 1'b1;
      if (w_lru_upd)   r_lru[w_idx] <= ~w_hit_way;
      if (w_refill_wr) begin
        r_valid[r_victim][w_idx] <= 1'b1;
        r_dirty[r_victim][w_idx] <= 1'b0;
      end
      if (w_flush_clr) r_dirty[r_scan_way][r_scan_set] <= 1'b0;
    end
  end

  // Data and tag arrays (not reset)
  always_ff @(posedge clk) begin
    if (w_store_hit) r_data[w_hit_way][w_idx][32'(w_off)*DATA_W +: DATA_W] <= cpu_wdata;
    if (w_refill_wr) begin
      r_data[r_victim][w_idx] <= mem_rdata;
      r_tag[r_victim][w_idx]  <= w_tag;
    end
  end

  assign cpu_ready  = w_cpu_ready;
  assign cpu_rdata  = (cpu_req && w_cpu_ready && !cpu_we) ? w_hit_word : '0;
  assign flush_done = r_flush_done;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_param_wb_cache.sv
// Testbench for param_wb_cache: directed vector table on a 2-way instance,
// hand-written flush/delay/reset sequences, and a direct-mapped instance.
module tb_param_wb_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, flush, mem_ready;
  logic [9:0]  cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
  logic        cpu_ready, flush_done, mem_req, mem_we;
  logic [19:0] mem_wdata, mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  // Direct-mapped instance, RAM responds immediately
  logic        c1_req, c1_ready, c1_flush_done, c1_mem_req, c1_mem_we, c1_mem_ready;
  logic [9:0]  c1_addr, c1_rdata, c1_mem_addr;
  logic [19:0] c1_mem_wdata, c1_mem_rdata;
  logic [15:0] c1_hit, c1_miss;
  int          n_ref1 = 0;

  always #5 clk = ~clk;

  param_wb_cache u_dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .flush(flush),
    .flush_done(flush_done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  param_wb_cache #(.WAYS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr),
    .cpu_wdata(10'h000), .cpu_rdata(c1_rdata), .cpu_ready(c1_ready), .flush(1'b0),
    .flush_done(c1_flush_done), .mem_req(c1_mem_req), .mem_we(c1_mem_we),
    .mem_addr(c1_mem_addr), .mem_wdata(c1_mem_wdata), .mem_rdata(c1_mem_rdata),
    .mem_ready(c1_mem_ready), .hit_cnt(c1_hit), .miss_cnt(c1_miss)
  );

  assign c1_mem_ready = c1_mem_req;
  assign c1_mem_rdata = {c1_mem_addr + 10'h101, c1_mem_addr + 10'h100};

  always @(posedge clk) if (c1_mem_req && c1_mem_ready && !c1_mem_we) n_ref1 <= n_ref1 + 1;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [9:0]  wdata;
    logic [9:0]  exp_rdata;
    logic        exp_hit;
    int          delay;
    logic        exp_wb;
    logic [9:0]  exp_wb_addr;
    logic [19:0] exp_wb_data;
  } vec_t;

  vec_t        vq[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Bench RAM model and transaction log
  logic [19:0] bmem [512];
  logic        in_txn, ready_given;
  int          wait_cnt;
  logic        txn_we;
  logic [9:0]  txn_addr;
  logic [19:0] txn_wdata;
  logic        log_we   [$];
  logic [9:0]  log_addr [$];
  logic [19:0] log_data [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add_vec(input logic we, input logic [9:0] addr, input logic [9:0] wdata,
                         input logic [9:0] rdata, input logic hit, input int delay,
                         input logic wb, input logic [9:0] wb_addr, input logic [19:0] wb_data);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.exp_rdata = rdata; v.exp_hit = hit;
    v.delay = delay; v.exp_wb = wb; v.exp_wb_addr = wb_addr; v.exp_wb_data = wb_data;
    vq.push_back(v);
  endtask

  // Called at each negedge: emulates RAM with `delay` wait cycles per transaction
  task automatic mem_serve(input int delay);
    if (ready_given) check("mem_req_drop", 32'(mem_req), 32'd0);
    ready_given = 1'b0;
    mem_ready   = 1'b0;
    if (mem_req) begin
      if (!in_txn) begin
        in_txn = 1'b1; wait_cnt = delay;
        txn_we = mem_we; txn_addr = mem_addr; txn_wdata = mem_wdata;
      end else begin
        check("stable_addr",  32'(mem_addr),  32'(txn_addr));
        check("stable_wdata", 32'(mem_wdata), 32'(txn_wdata));
      end
      if (wait_cnt == 0) begin
        mem_ready = 1'b1;
        log_we.push_back(mem_we);
        log_addr.push_back(mem_addr);
        if (mem_we) begin
          bmem[mem_addr[9:1]] = mem_wdata;
          log_data.push_back(mem_wdata);
        end else begin
          mem_rdata = bmem[mem_addr[9:1]];
          log_data.push_back(mem_rdata);
        end
        in_txn = 1'b0; ready_given = 1'b1;
      end else begin
        wait_cnt--;
      end
    end
  endtask

  // Starts at posedge+1; returns at posedge+1 after the access has completed
  task automatic access(input vec_t v);
    int   cyc;
    logic got;
    int   n_rd, n_wr;
    logic [9:0]  rf_addr, wb_addr;
    logic [19:0] wb_data;
    cyc = 0; got = 1'b0; n_rd = 0; n_wr = 0; rf_addr = '0; wb_addr = '0; wb_data = '0;
    log_we.delete(); log_addr.delete(); log_data.delete();
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    while (!got && cyc < 100) begin
      @(negedge clk);
      mem_serve(v.delay);
      if (cpu_ready) begin
        got = 1'b1;
        check("latency_is_hit", 32'(cyc == 0), 32'(v.exp_hit));
        check("rdata", 32'(cpu_rdata), 32'(v.exp_rdata));
      end else begin
        cyc++;
      end
      @(posedge clk); #1;
    end
    check("ready_in_budget", 32'(got), 32'd1);
    cpu_req = 1'b0;
    foreach (log_we[i]) begin
      if (log_we[i]) begin n_wr++; wb_addr = log_addr[i]; wb_data = log_data[i]; end
      else begin n_rd++; rf_addr = log_addr[i]; end
    end
    check("n_refill", 32'(n_rd), v.exp_hit ? 32'd0 : 32'd1);
    check("n_writeback", 32'(n_wr), 32'(v.exp_wb));
    if (!v.exp_hit) check("refill_addr", 32'(rf_addr), 32'(v.addr & 10'h3FE));
    if (v.exp_wb) begin
      check("wb_addr", 32'(wb_addr), 32'(v.exp_wb_addr));
      check("wb_data", 32'(wb_data), 32'(v.exp_wb_data));
    end
  endtask

  task automatic do_flush(input int exp_wr, input logic [9:0] a0, input logic [19:0] d0,
                          input logic [9:0] a1, input logic [19:0] d1);
    logic done;
    int   busy_ready;
    done = 1'b0; busy_ready = 0;
    log_we.delete(); log_addr.delete(); log_data.delete();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      mem_serve(0);
      if (mem_req && cpu_ready) busy_ready++;
      if (flush_done) done = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_done_seen", 32'(done), 32'd1);
    @(negedge clk);
    check("flush_done_1cyc", 32'(flush_done), 32'd0);
    check("ready_while_busy", 32'(busy_ready), 32'd0);
    check("flush_n_tx", 32'(log_we.size()), 32'(exp_wr));
    if (log_we.size() == 2 && exp_wr == 2) begin
      check("flush_we0", 32'(log_we[0]), 32'd1);
      check("flush_we1", 32'(log_we[1]), 32'd1);
      check("flush_addr0", 32'(log_addr[0]), 32'(a0));
      check("flush_data0", 32'(log_data[0]), 32'(d0));
      check("flush_addr1", 32'(log_addr[1]), 32'(a1));
      check("flush_data1", 32'(log_data[1]), 32'(d1));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 512; i++) bmem[i] = {10'(2*i + 'h101), 10'(2*i + 'h100)};
    bmem[2] = {10'h0AB, 10'h0CD};

    // we, addr, wdata, exp_rdata, hit, delay, wb, wb_addr, wb_data
    add_vec(0, 10'h005, 10'h000, 10'h0AB, 0, 0, 0, 10'h000, 20'h0);
    add_vec(0, 10'h004, 10'h000, 10'h0CD, 1, 0, 0, 10'h000, 20'h0);
    add_vec(1, 10'h004, 10'h155, 10'h000, 1, 0, 0, 10'h000, 20'h0);
    add_vec(0, 10'h014, 10'h000, 10'h114, 0, 1, 0, 10'h000, 20'h0);
    add_vec(0, 10'h004, 10'h000, 10'h155, 1, 0, 0, 10'h000, 20'h0);
    add_vec(0, 10'h024, 10'h000, 10'h124, 0, 0, 0, 10'h000, 20'h0);
    add_vec(0, 10'h014, 10'h000, 10'h114, 0, 2, 1, 10'h004, {10'h0AB, 10'h155});
    add_vec(1, 10'h001, 10'h2AA, 10'h000, 0, 0, 0, 10'h000, 20'h0);
    add_vec(1, 10'h00E, 10'h077, 10'h000, 0, 0, 0, 10'h000, 20'h0);
    add_vec(0, 10'h001, 10'h000, 10'h2AA, 1, 0, 0, 10'h000, 20'h0);
    add_vec(1, 10'h000, 10'h333, 10'h000, 1, 0, 0, 10'h000, 20'h0);
    add_vec(0, 10'h030, 10'h000, 10'h130, 0, 0, 0, 10'h000, 20'h0);
    add_vec(0, 10'h040, 10'h000, 10'h140, 0, 5, 1, 10'h000, {10'h2AA, 10'h333});

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0; c1_req = 1'b0; c1_addr = '0;
    in_txn = 1'b0; ready_given = 1'b0; wait_cnt = 0;
    txn_we = 1'b0; txn_addr = '0; txn_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_counters", 32'({hit_cnt, miss_cnt}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) access(vq[i]);
    check("hit_cnt_a", 32'(hit_cnt), 32'd4);
    check("miss_cnt_a", 32'(miss_cnt), 32'd6);

    do_flush(2, 10'h000, {10'h2AA, 10'h100}, 10'h00E, {10'h10F, 10'h077});
    do_flush(0, 10'h000, 20'h0, 10'h000, 20'h0);

    for (int i = 10; i < 13; i++) access(vq[i]);
    check("hit_cnt_b", 32'(hit_cnt), 32'd5);
    check("miss_cnt_b", 32'(miss_cnt), 32'd8);

    // Reset while a refill is outstanding
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h050;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    check("rst_test_req_seen", 32'(seen), 32'd1);
    rst_n = 1'b0; cpu_req = 1'b0; mem_ready = 1'b0; in_txn = 1'b0; ready_given = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("midrst_miss_cnt", 32'(miss_cnt), 32'd0);
    check("midrst_cpu_ready", 32'(cpu_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    begin
      vec_t v;
      v.we = 1'b0; v.addr = 10'h040; v.wdata = '0; v.exp_rdata = 10'h140; v.exp_hit = 1'b0;
      v.delay = 0; v.exp_wb = 1'b0; v.exp_wb_addr = '0; v.exp_wb_data = '0;
      access(v);
    end
    check("post_rst_miss", 32'(miss_cnt), 32'd1);
    check("post_rst_hit", 32'(hit_cnt), 32'd0);

    // Direct-mapped: alternating lines in one set always conflict
    for (int i = 0; i < 4; i++) begin
      int   cyc;
      logic got;
      logic [9:0] a;
      a = (i % 2 == 0) ? 10'h004 : 10'h014;
      cyc = 0; got = 1'b0;
      c1_req = 1'b1; c1_addr = a;
      while (!got && cyc < 20) begin
        @(negedge clk);
        if (c1_ready) begin
          got = 1'b1;
          check("dm_rdata", 32'(c1_rdata), 32'(a + 10'h100));
          check("dm_missed", 32'(cyc > 0), 32'd1);
        end else cyc++;
        @(posedge clk); #1;
      end
      check("dm_ready_in_budget", 32'(got), 32'd1);
      c1_req = 1'b0;
    end
    @(negedge clk);
    check("dm_miss_cnt", 32'(c1_miss), 32'd4);
    check("dm_hit_cnt", 32'(c1_hit), 32'd0);
    check("dm_refills", 32'(n_ref1), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
